// File: rtl/exponent_accelerator_sw_poller_if.sv
// Avalon-MM read-only bus between the switch poller (master) and the switch PIO (slave).
interface exponent_accelerator_sw_poller_if;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic [31:0] avm_readdata;
   logic        avm_waitrequest;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_readdata,
      input  avm_waitrequest
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_readdata,
      output avm_waitrequest
   );
endinterface

// File: rtl/exponent_accelerator_sw_poller.sv
// Periodically reads the switch PIO over Avalon-MM and debounces the result,
// presenting a stable switch word plus a one-cycle change strobe.
module exponent_accelerator_sw_poller #(
   parameter int DATA_W         = 10,
   parameter int POLL_CYCLES    = 50000,
   parameter int STABLE_SAMPLES = 4,
   parameter int READ_LATENCY   = 1
) (
   input  logic                            clk,
   input  logic                            reset,
   exponent_accelerator_sw_poller_if.master avm,
   input  logic                            enable,
   output logic [DATA_W-1:0]               sw_value,
   output logic                            sw_changed
);

   localparam int TIMER_W = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
   localparam int CNT_W   = $clog2(STABLE_SAMPLES + 1);

   localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_CYCLES - 1);
   localparam logic [CNT_W-1:0]   CNT_FULL     = CNT_W'(STABLE_SAMPLES);
   localparam logic [2:0]         LAT_LAST     = 3'(READ_LATENCY);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] LAT  = 2'd2;
   localparam logic [1:0] UPD  = 2'd3;

   logic [1:0]         state;
   logic [TIMER_W-1:0] timer;
   logic [2:0]         lat_cnt;
   logic [DATA_W-1:0]  sample;
   logic [DATA_W-1:0]  candidate;
   logic [CNT_W-1:0]   stable_cnt;
   logic [DATA_W-1:0]  next_candidate;
   logic [CNT_W-1:0]   next_cnt;
   logic               unused_readdata_bits;

   assign avm.avm_address    = 2'd0;
   assign avm.avm_read       = (state == REQ);
   assign unused_readdata_bits = ^avm.avm_readdata[31:DATA_W];

   // A differing sample restarts the run; a matching one extends it up to saturation.
   always_comb begin
      next_candidate = candidate;
      next_cnt       = stable_cnt;
      if (sample == candidate) begin
         if (stable_cnt != CNT_FULL) begin
            next_cnt = stable_cnt + CNT_W'(1);
         end
      end else begin
         next_candidate = sample;
         next_cnt       = CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= TIMER_RELOAD;
         lat_cnt    <= 3'd0;
         sample     <= '0;
         candidate  <= '0;
         stable_cnt <= '0;
         sw_value   <= '0;
         sw_changed <= 1'b0;
      end else begin
         sw_changed <= 1'b0;
         case (state)
            IDLE: begin
               if (!enable) begin
                  timer <= TIMER_RELOAD;
               end else if (timer == '0) begin
                  timer <= TIMER_RELOAD;
                  state <= REQ;
               end else begin
                  timer <= timer - TIMER_W'(1);
               end
            end
            REQ: begin
               if (!avm.avm_waitrequest) begin
                  lat_cnt <= 3'd1;
                  state   <= LAT;
               end
            end
            // Accepted reads always run to completion, even if enable drops.
            LAT: begin
               if (lat_cnt == LAT_LAST) begin
                  sample <= avm.avm_readdata[DATA_W-1:0];
                  state  <= UPD;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            default: begin
               candidate  <= next_candidate;
               stable_cnt <= next_cnt;
               if (next_cnt == CNT_FULL && next_candidate != sw_value) begin
                  sw_value   <= next_candidate;
                  sw_changed <= 1'b1;
               end
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
